// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester round-robin arbiter in front of a shared combinational ALU
module alu_arbiter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [3:0]      req0_op,
  input  logic [XLEN-1:0] req0_a,
  input  logic [XLEN-1:0] req0_b,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [3:0]      req1_op,
  input  logic [XLEN-1:0] req1_a,
  input  logic [XLEN-1:0] req1_b,
  output logic            rsp0_valid,
  input  logic            rsp0_ready,
  output logic [XLEN-1:0] rsp0_data,
  output logic            rsp1_valid,
  input  logic            rsp1_ready,
  output logic [XLEN-1:0] rsp1_data,
  output logic [3:0]      alu_op_o,
  output logic [XLEN-1:0] alu_a_o,
  output logic [XLEN-1:0] alu_b_o,
  input  logic [XLEN-1:0] alu_data_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic            last_grant;
  logic            owner;
  logic            winner;
  logic            accept;
  logic            rsp_done;
  logic [3:0]      op_q;
  logic [XLEN-1:0] a_q;
  logic [XLEN-1:0] b_q;
  logic [XLEN-1:0] res_q;

  // Pick the winner: a lone requester wins, a tie goes to whoever was not granted last
  always_comb begin
    winner = 1'b0;
    if (req0_valid && req1_valid) begin
      winner = ~last_grant;
    end else if (req1_valid) begin
      winner = 1'b1;
    end
  end

  // Ready is combinational, so it is also gated by reset to keep it low while rst_n is asserted
  assign accept   = rst_n && (state == IDLE) && (req0_valid || req1_valid);
  assign rsp_done = (state == RESP) && (owner ? rsp1_ready : rsp0_ready);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic: one transaction in flight, IDLE -> EXEC -> RESP -> IDLE
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept)   state_nx = EXEC;
      EXEC:                  state_nx = RESP;
      RESP:    if (rsp_done) state_nx = IDLE;
      default:               state_nx = IDLE;
    endcase
  end

  // Output logic: grant only the winner in IDLE, present the result only to the owner in RESP
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    rsp0_data  = '0;
    rsp1_data  = '0;
    if (accept) begin
      req0_ready = ~winner;
      req1_ready = winner;
    end
    if (state == RESP) begin
      if (owner) begin
        rsp1_valid = 1'b1;
        rsp1_data  = res_q;
      end else begin
        rsp0_valid = 1'b1;
        rsp0_data  = res_q;
      end
    end
  end

  // Transaction registers: operands latched on accept, ALU result captured in EXEC
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
      owner      <= 1'b0;
      op_q       <= 4'b0000;
      a_q        <= '0;
      b_q        <= '0;
      res_q      <= '0;
    end else begin
      if (accept) begin
        last_grant <= winner;
        owner      <= winner;
        op_q       <= winner ? req1_op : req0_op;
        a_q        <= winner ? req1_a  : req0_a;
        b_q        <= winner ? req1_b  : req0_b;
      end
      if (state == EXEC) begin
        res_q <= alu_data_i;
      end
    end
  end

  // The shared ALU only ever sees latched values, so requesters may change inputs after accept
  assign alu_op_o = op_q;
  assign alu_a_o  = a_q;
  assign alu_b_o  = b_q;

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter XLEN, default 32, data width of operands and result.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req0_valid  input  1  requester 0 has an operation pending.
REQ-005 req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-006 req0_op  input  4  requester 0 ALU operation code.
REQ-007 req0_a / req0_b  input  XLEN each  requester 0 operands A and B.
REQ-008 req1_valid, req1_ready, req1_op, req1_a, req1_b  same as REQ-004..007, requester 1.
REQ-009 rsp0_valid  output  1  result for requester 0 available.
REQ-010 rsp0_ready  input  1  requester 0 consumes result.
REQ-011 rsp0_data  output  XLEN  result for requester 0.
REQ-012 rsp1_valid, rsp1_ready, rsp1_data  same as REQ-009..011, requester 1.
REQ-013 alu_op_o  output  4  operation code driven to the shared ALU.
REQ-014 alu_a_o / alu_b_o  output  XLEN each  operands driven to the shared ALU.
REQ-015 alu_data_i  input  XLEN  combinational result returned by the shared ALU.

Function
REQ-016 FSM states IDLE, EXEC, RESP; the block SHALL hold at most one transaction in flight.
REQ-017 IDLE: if no reqN_valid, stay in IDLE; otherwise select a winner, assert reqN_ready for the winner only (combinational, same cycle), latch winner op/a/b and owner id, and go to EXEC.
REQ-018 Arbitration: one valid -> that requester wins; both valid -> the requester NOT granted last wins (round-robin); last_grant updates on every accept.
REQ-019 reqN_ready SHALL be 0 in EXEC and RESP and for the losing requester.
REQ-020 alu_op_o/alu_a_o/alu_b_o SHALL always be driven from the latched op/operand registers, never directly from request inputs.
REQ-021 EXEC: capture alu_data_i into the result register and go to RESP; the op code is forwarded unmodified (undefined codes yield whatever the ALU returns, normally 0).
REQ-022 RESP: assert rspN_valid for the owner only with rspN_data = result register; hold both stable until rspN_ready = 1, then return to IDLE on that edge.
REQ-023 rspN_ready while the matching rspN_valid = 0 SHALL be ignored; rsp_data of the non-owner SHALL read 0.
REQ-024 Latency: accept at edge N -> rspN_valid high from cycle N+2; with rsp_ready held high the minimum issue interval is 3 cycles.
REQ-025 A request may drop reqN_valid before being accepted; no state change results.
REQ-026 No new request SHALL be accepted in the cycle a response completes; the next accept occurs in IDLE at the earliest one cycle later.

Reset
REQ-027 rst_n low SHALL immediately force: state IDLE, last_grant = requester 1 (so requester 0 wins first tie), op/operand/result registers 0, all ready/valid outputs 0, alu_op_o = 4'b0000, alu_a_o = alu_b_o = 0.
REQ-028 Reset asserted mid-transaction (EXEC or RESP) SHALL discard the transaction; no response is produced after reset release.
REQ-029 After rst_n deasserts, the block SHALL accept a request on the first rising edge with a valid request.

Verification
REQ-030 Single request: req0 op=0000 (add) a=5 b=7 -> req0_ready same cycle, rsp0_valid two cycles later with rsp0_data=12, rsp1_valid stays 0.
REQ-031 Tie after reset: req0 and req1 valid together (req0 sub 10-3, req1 xor F0^0F) -> req0 served first (rsp0_data=7), then req1 (rsp1_data=0xFF).
REQ-032 Round-robin: both requesters hold valid continuously for 4 transactions -> grants alternate 0,1,0,1.
REQ-033 Back-pressure: rsp1_ready low 5 cycles in RESP -> rsp1_valid and rsp1_data held stable, both req_ready 0 throughout, completion on first cycle rsp1_ready=1.
REQ-034 Reset mid-op: assert rst_n low in EXEC -> all outputs 0 immediately, no rsp_valid after release, next request served normally.
REQ-035 Operand isolation: change req0_a after accept -> alu_a_o and result unaffected (SLT of 0xFFFFFFFF vs 1 returns 1).
